mini_cpu_datapath: RTL and testbench
====================================

// Module: mini_cpu_datapath
// PURPOSE
//   Execution core of the mini-CPU: a 16x16-bit register RAM plus an ALU.
//   Executes one 3-bit-opcode instruction per enviar strobe and writes the result to RAM[dest].
//   Drives the result onto valor_final, plus a display-enable flag for the LCD front end.
//   Sits between the switch/button input logic and the LCD driver.
// PARAMETERS
//   DATA_W  16  register/result width
//   ADDR_W  4   register address width; depth = 2**ADDR_W (16)
//   IMM_W   6   immediate magnitude width
// PORTS
//   clk             in   1       system clock; all state changes on posedge
//   rst_n           in   1       reset, asynchronous, active-low
//   opcode          in   3       000 LOAD,001 ADD,010 ADDI,011 SUB,100 SUBI,101 MUL,110 CLEAR,111 DISPLAY
//   src1            in   ADDR_W  first operand address
//   src2            in   ADDR_W  second operand address
//   dest            in   ADDR_W  destination address
//   sinal_imm       in   1       immediate sign: 0 = +, 1 = -
//   imm             in   IMM_W   immediate magnitude
//   we              in   1       global write enable; 0 blocks all RAM writes
//   enviar          in   1       execute request; acts on its rising edge
//   valor_final     out  DATA_W  last result, registered
//   mostrar_nums    out  1       1 = LCD shows numbers
//   pronto          out  1       one-cycle pulse: instruction completed
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - all 16 RAM words = 0; valor_final = 0; mostrar_nums = 0; pronto = 0.
//     - Edge-detect flop enviar_q = 0.
//   - Start detect: on posedge clk, start = enviar & ~enviar_q; enviar_q <= enviar.
//     - If enviar is already high at reset release, it triggers once.
//     - Holding enviar high executes only one instruction.
//   - Latency: at the clk edge where start=1, operands are read, result computed,
//     RAM written, valor_final/mostrar_nums updated, and pronto set to 1 for exactly that following cycle.
//   - Immediate: immv = sinal_imm ? -{0,imm} : {0,imm}, as 16-bit two's complement (range -63..+63).
//   - Operations (A = RAM[src1], B = RAM[src2]; all arithmetic mod 2^16):
//       LOAD    r = immv;      RAM[dest] <= r; mostrar_nums <= 1
//       ADD     r = A + B;     RAM[dest] <= r; mostrar_nums <= 1
//       ADDI    r = A + immv;  RAM[dest] <= r; mostrar_nums <= 1
//       SUB     r = A - B;     RAM[dest] <= r; mostrar_nums <= 1
//       SUBI    r = A - immv;  RAM[dest] <= r; mostrar_nums <= 1
//       MUL     r = low 16 bits of signed A*B; RAM[dest] <= r; mostrar_nums <= 1
//       CLEAR   all 16 words <= 0; r = 0; mostrar_nums <= 0
//       DISPLAY r = A; no write; mostrar_nums <= 1
//     valor_final <= r in every case.
//   - we=0: RAM unchanged, including CLEAR; valor_final, mostrar_nums and pronto update as normal.
//   - Read-before-write: dest == src1/src2 uses the pre-edge operand value.
//   - Overflow wraps silently; no flags.
//   - Without start, all outputs hold and pronto = 0.
//   - Reset mid-operation: immediate clear; a pending instruction is discarded.
//   - Operand inputs only need to be stable at the start edge.
// TESTING
//   1. LOAD dest=3 imm=5 sinal=0, we=1, pulse enviar -> RAM[3]=5, valor_final=0x0005, pronto 1 cycle.
//   2. LOAD r1=+7, LOAD r2=-3 (sinal=1), ADD dest=4 -> 0x0004; SUB dest=5 -> 0x000A; MUL dest=6 -> 0xFFEB.
//   3. ADDI src1=r4(4) imm=63 -> 0x0043; SUBI imm=63 sinal=1 -> 4+63=0x0043; r=0x7FFF ADDI 1 -> 0x8000 (wrap).
//   4. CLEAR -> every DISPLAY of r0..r15 gives 0, mostrar_nums=0; then DISPLAY r0 -> mostrar_nums=1.
//   5. we=0, LOAD dest=2 imm=9 -> valor_final=9, but DISPLAY r2 still shows the old value.
//   6. enviar held high 10 cycles -> a single pronto pulse; assert rst_n=0 mid-sequence -> all outputs 0 at once.

Source files
------------

// File: rtl/mini_cpu_datapath.sv
// Execution core of the mini-CPU: 16-word register RAM plus ALU.
// Runs one instruction per rising edge of enviar, writes RAM[dest] and drives valor_final.
module mini_cpu_datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [ADDR_W-1:0] dest,
  input  logic              sinal_imm,
  input  logic [IMM_W-1:0]  imm,
  input  logic              we,
  input  logic              enviar,
  output logic [DATA_W-1:0] valor_final,
  output logic              mostrar_nums,
  output logic              pronto
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_ADD     = 3'b001,
    OP_ADDI    = 3'b010,
    OP_SUB     = 3'b011,
    OP_SUBI    = 3'b100,
    OP_MUL     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_DISPLAY = 3'b111
  } op_t;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              enviar_q;
  logic              start;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] immv;
  logic [DATA_W-1:0] mul_lo;
  logic [DATA_W-1:0] result;
  logic              write_one;
  logic              write_all;
  logic              show;

  assign start   = enviar & ~enviar_q;
  assign op_a    = regs[src1];
  assign op_b    = regs[src2];
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
  assign immv    = sinal_imm ? (DATA_W'(0) - imm_ext) : imm_ext;
  // The low half of a product is the same for signed and unsigned operands.
  assign mul_lo  = op_a * op_b;

  always_comb begin
    result    = '0;
    write_one = 1'b0;
    write_all = 1'b0;
    show      = 1'b1;
    case (op_t'(opcode))
      OP_LOAD: begin
        result    = immv;
        write_one = 1'b1;
      end
      OP_ADD: begin
        result    = op_a + op_b;
        write_one = 1'b1;
      end
      OP_ADDI: begin
        result    = op_a + immv;
        write_one = 1'b1;
      end
      OP_SUB: begin
        result    = op_a - op_b;
        write_one = 1'b1;
      end
      OP_SUBI: begin
        result    = op_a - immv;
        write_one = 1'b1;
      end
      OP_MUL: begin
        result    = mul_lo;
        write_one = 1'b1;
      end
      OP_CLEAR: begin
        result    = '0;
        write_all = 1'b1;
        show      = 1'b0;
      end
      OP_DISPLAY: begin
        result    = op_a;
      end
      default: begin
        result    = '0;
      end
    endcase
  end

  // Operands are read combinationally, so dest == src sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enviar_q     <= 1'b0;
      valor_final  <= '0;
      mostrar_nums <= 1'b0;
      pronto       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      enviar_q <= enviar;
      pronto   <= start;
      if (start) begin
        valor_final  <= result;
        mostrar_nums <= show;
        if (we && write_all) begin
          for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
          end
        end else if (we && write_one) begin
          regs[dest] <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_mini_cpu_datapath.sv
// Self-checking bench for mini_cpu_datapath: table-driven instruction vectors
// followed by hand-written sequences for hold, reset and reset-release cases.
module tb_mini_cpu_datapath;

  localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, ADDI = 3'b010, SUB = 3'b011,
                         SUBI = 3'b100, MUL = 3'b101, CLR = 3'b110, DISP = 3'b111;

  logic        clk;
  logic        rst_n;
  logic [2:0]  opcode;
  logic [3:0]  src1, src2, dest;
  logic        sinal_imm;
  logic [5:0]  imm;
  logic        we;
  logic        enviar;
  logic [15:0] valor_final;
  logic        mostrar_nums;
  logic        pronto;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  d;
    logic        sg;
    logic [5:0]  im;
    logic        w;
    logic [15:0] exp_val;
    logic        exp_show;
  } vec_t;

  vec_t vecs[$];

  mini_cpu_datapath dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .src1         (src1),
    .src2         (src2),
    .dest         (dest),
    .sinal_imm    (sinal_imm),
    .imm          (imm),
    .we           (we),
    .enviar       (enviar),
    .valor_final  (valor_final),
    .mostrar_nums (mostrar_nums),
    .pronto       (pronto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [2:0] op, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic sg, input logic [5:0] im,
                        input logic w, input logic [15:0] ev, input logic es);
    vec_t v;
    v.op = op; v.s1 = s1; v.s2 = s2; v.d = d; v.sg = sg; v.im = im; v.w = w;
    v.exp_val = ev; v.exp_show = es;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    opcode = v.op; src1 = v.s1; src2 = v.s2; dest = v.d;
    sinal_imm = v.sg; imm = v.im; we = v.w; enviar = 1'b1;
    @(posedge clk); #1;
    checkOutput($sformatf("vec%0d pronto", idx), {15'd0, pronto}, 16'd1);
    checkOutput($sformatf("vec%0d valor_final", idx), valor_final, v.exp_val);
    checkOutput($sformatf("vec%0d mostrar_nums", idx), {15'd0, mostrar_nums}, {15'd0, v.exp_show});
    @(negedge clk);
    enviar = 1'b0;
    opcode = LOAD; imm = 6'd33;
    @(posedge clk); #1;
    checkOutput($sformatf("vec%0d pronto low", idx), {15'd0, pronto}, 16'd0);
    checkOutput($sformatf("vec%0d valor hold", idx), valor_final, v.exp_val);
  endtask

  initial begin
    int pulses;

    rst_n = 1'b0; enviar = 1'b0; opcode = LOAD; src1 = '0; src2 = '0; dest = '0;
    sinal_imm = 1'b0; imm = '0; we = 1'b1;

    //     op    s1 s2 d  sg im  w  expected   show
    addVec(LOAD, 0, 0, 3, 0, 5,  1, 16'h0005, 1);
    addVec(LOAD, 0, 0, 1, 0, 7,  1, 16'h0007, 1);
    addVec(LOAD, 0, 0, 2, 1, 3,  1, 16'hFFFD, 1);
    addVec(ADD,  1, 2, 4, 0, 0,  1, 16'h0004, 1);
    addVec(SUB,  1, 2, 5, 0, 0,  1, 16'h000A, 1);
    addVec(MUL,  1, 2, 6, 0, 0,  1, 16'hFFEB, 1);
    addVec(ADDI, 4, 0, 7, 0, 63, 1, 16'h0043, 1);
    addVec(SUBI, 4, 0, 8, 1, 63, 1, 16'h0043, 1);
    addVec(SUB,  2, 1, 15, 0, 0, 1, 16'hFFF6, 1);
    addVec(MUL,  2, 2, 15, 0, 0, 1, 16'h0009, 1);
    addVec(LOAD, 0, 0, 9, 0, 16, 1, 16'h0010, 1);
    addVec(MUL,  9, 9, 10, 0, 0, 1, 16'h0100, 1);
    addVec(MUL, 10, 9, 11, 0, 0, 1, 16'h1000, 1);
    addVec(LOAD, 0, 0, 12, 0, 8, 1, 16'h0008, 1);
    addVec(MUL, 11, 12, 13, 0, 0, 1, 16'h8000, 1);
    addVec(SUBI, 13, 0, 13, 0, 1, 1, 16'h7FFF, 1);
    addVec(ADDI, 13, 0, 14, 0, 1, 1, 16'h8000, 1);
    addVec(DISP, 3, 0, 0, 0, 0,  1, 16'h0005, 1);
    addVec(ADD,  3, 3, 3, 0, 0,  1, 16'h000A, 1);
    addVec(DISP, 3, 0, 0, 0, 0,  1, 16'h000A, 1);
    addVec(LOAD, 0, 0, 2, 0, 9,  0, 16'h0009, 1);
    addVec(DISP, 2, 0, 0, 0, 0,  1, 16'hFFFD, 1);
    addVec(CLR,  0, 0, 0, 0, 0,  0, 16'h0000, 0);
    addVec(DISP, 1, 0, 0, 0, 0,  1, 16'h0007, 1);
    addVec(CLR,  0, 0, 0, 0, 0,  1, 16'h0000, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset valor_final", valor_final, 16'h0000);
    checkOutput("reset mostrar_nums", {15'd0, mostrar_nums}, 16'd0);
    checkOutput("reset pronto", {15'd0, pronto}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle pronto", {15'd0, pronto}, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // After CLEAR every register reads back zero.
    for (int r = 0; r < 16; r++) begin
      vec_t v;
      v.op = DISP; v.s1 = 4'(r); v.s2 = '0; v.d = '0; v.sg = 1'b0; v.im = '0; v.w = 1'b1;
      v.exp_val = 16'h0000; v.exp_show = 1'b1;
      applyStimulus(v, 100 + r);
    end

    // enviar held high for ten cycles executes exactly once.
    @(negedge clk);
    opcode = LOAD; dest = 4'd5; sinal_imm = 1'b0; imm = 6'd1; we = 1'b1; enviar = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (pronto) pulses++;
    end
    checkOutput("held enviar pulse count", 16'(pulses), 16'd1);
    checkOutput("held enviar valor", valor_final, 16'h0001);

    // Asynchronous reset mid-cycle clears outputs immediately.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset valor", valor_final, 16'h0000);
    checkOutput("async reset mostrar", {15'd0, mostrar_nums}, 16'd0);
    checkOutput("async reset pronto", {15'd0, pronto}, 16'd0);

    // enviar still high at reset release triggers one instruction; RAM was wiped.
    @(negedge clk);
    opcode = DISP; src1 = 4'd5;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release pronto", {15'd0, pronto}, 16'd1);
    checkOutput("release valor r5", valor_final, 16'h0000);
    checkOutput("release mostrar", {15'd0, mostrar_nums}, 16'd1);
    @(posedge clk); #1;
    checkOutput("release pronto single", {15'd0, pronto}, 16'd0);
    @(negedge clk);
    enviar = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
